// File: rtl/fp_log_iter.sv
// fp_log_iter: multi-cycle binary32 log2, one fraction bit per cycle by mantissa squaring.
// Define FP_LOG_BASE_SEL_EN to add the SCALE stage that rescales the result to ln or log10.
module fp_log_iter #(
  parameter int FRAC_BITS = 24,
  parameter int MW        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [1:0]  in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic [1:0]  out_flags
);
  localparam int RW = 9 + FRAC_BITS;
  localparam int CW = $clog2(FRAC_BITS + 1);
`ifdef FP_LOG_BASE_SEL_EN
  localparam int PW = RW + 32;
  localparam int PF = FRAC_BITS + 32;
`else
  localparam int PW = RW;
  localparam int PF = FRAC_BITS;
`endif
  localparam int NW = PW + 26;
  localparam int KW = $clog2(PW) + 1;

  typedef enum logic [2:0] {IDLE, NORM, ITER, SCALE, PACK, DONE} state_e;

  state_e            state_q, state_d;
  logic [30:0]       x_q, x_d;
  logic signed [8:0] e_q, e_d;
  logic [MW-1:0]     m_q, m_d;
  logic [FRAC_BITS-1:0] f_q, f_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       y_q, y_d;
  logic [1:0]        fl_q, fl_d;
  logic              rdy_q, rdy_d;
  logic              vld_q, vld_d;
`ifdef FP_LOG_BASE_SEL_EN
  logic [1:0]        mode_q, mode_d;
  logic [PW-1:0]     p_q, p_d;
  logic [PW-1:0]     c_w;
`else
  logic              unused_mode;
  assign unused_mode = ^in_mode;
`endif

  logic        is_zero, is_nan, is_inf, special;
  logic [31:0] sp_y;
  logic [1:0]  sp_fl;

  assign is_zero = in_x[30:0] == 31'd0;
  assign is_nan  = (in_x[30:23] == 8'hFF) && (in_x[22:0] != 23'd0);
  assign is_inf  = (in_x[30:23] == 8'hFF) && (in_x[22:0] == 23'd0);

  always_comb begin
    sp_y    = 32'h0;
    sp_fl   = 2'b00;
    special = 1'b1;
    if (is_zero) begin
      sp_y  = 32'hFF80_0000;
      sp_fl = 2'b01;
    end else if (is_nan) begin
      sp_y  = 32'h7FC0_0000;
      sp_fl = {~in_x[22], 1'b0};
    end else if (in_x[31]) begin
      sp_y  = 32'h7FC0_0000;
      sp_fl = 2'b10;
    end else if (is_inf) begin
      sp_y  = 32'h7F80_0000;
    end else if (in_x != 32'h3F80_0000) begin
      special = 1'b0;
    end
  end

  // Subnormals: shift the leading one out so m is again 1.frac
  logic [4:0]        lz;
  logic signed [8:0] n_e;
  logic [22:0]       n_f;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 23; i++)
      if (x_q[i]) lz = 5'(22 - i);
    if (x_q[30:23] == 8'd0) begin
      n_e = -9'sd127 - $signed({4'b0, lz});
      n_f = x_q[22:0] << (lz + 5'd1);
    end else begin
      n_e = $signed({1'b0, x_q[30:23]}) - 9'sd127;
      n_f = x_q[22:0];
    end
  end

  logic [2*MW-1:0] sq;
  logic            bit_i;
  logic [MW-1:0]   m_nx;
  logic            unused_sq;

  assign sq        = {{MW{1'b0}}, m_q} * {{MW{1'b0}}, m_q};
  assign bit_i     = sq[2*MW-1];
  assign m_nx      = bit_i ? sq[2*MW-1 -: MW] : sq[2*MW-2 -: MW];
  assign unused_sq = ^sq[MW-2:0];

  logic [RW-1:0] r, mag;
  logic          neg;

  assign r   = {e_q, f_q};
  assign neg = e_q[8];
  assign mag = neg ? -r : r;

`ifdef FP_LOG_BASE_SEL_EN
  // 2^32 acts as 1.0 in Q0.32 so log2 shares the product path
  always_comb begin
    case (mode_q)
      2'b01:   c_w = PW'(32'hB172_17F8);
      2'b10:   c_w = PW'(32'h4D10_4D42);
      default: c_w = PW'(33'h1_0000_0000);
    endcase
    p_d = PW'(mag) * c_w;
  end
`endif

  logic [PW-1:0] src;
  logic [KW-1:0] k;
  logic [NW-1:0] norm;
  logic [23:0]   sig;
  logic          gd, st;
  logic [24:0]   sig_r;
  logic [7:0]    be;
  logic [31:0]   y_pk;

  always_comb begin
`ifdef FP_LOG_BASE_SEL_EN
    src = p_q;
`else
    src = mag;
`endif
    k = '0;
    for (int i = 0; i < PW; i++)
      if (src[i]) k = KW'(i);
    norm  = {src, 26'd0} << (KW'(PW - 1) - k);
    sig   = norm[NW-1 -: 24];
    gd    = norm[NW-25];
    st    = |norm[NW-26:0];
    sig_r = {1'b0, sig} + 25'(gd & (st | sig[0]));
    be    = 8'(k) + 8'(127 - PF) + 8'(sig_r[24]);
    y_pk  = {neg, be, sig_r[24] ? sig_r[23:1] : sig_r[22:0]};
    if (src == '0) y_pk = 32'h0;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    e_d     = e_q;
    m_d     = m_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    fl_d    = fl_q;
`ifdef FP_LOG_BASE_SEL_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        if (special) begin
          y_d     = sp_y;
          fl_d    = sp_fl;
          state_d = DONE;
        end else begin
          x_d     = in_x[30:0];
`ifdef FP_LOG_BASE_SEL_EN
          mode_d  = in_mode;
`endif
          state_d = NORM;
        end
      end
      NORM: begin
        e_d     = n_e;
        m_d     = {1'b1, n_f, {(MW-24){1'b0}}};
        f_d     = '0;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        m_d   = m_nx;
        f_d   = {f_q[FRAC_BITS-2:0], bit_i};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(FRAC_BITS - 1))
`ifdef FP_LOG_BASE_SEL_EN
          state_d = SCALE;
`else
          state_d = PACK;
`endif
      end
`ifdef FP_LOG_BASE_SEL_EN
      SCALE: state_d = PACK;
`endif
      PACK: begin
        y_d     = y_pk;
        fl_d    = 2'b00;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d = state_d == IDLE;
    vld_d = state_d == DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      fl_q    <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
`ifdef FP_LOG_BASE_SEL_EN
      mode_q  <= '0;
      p_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      e_q     <= e_d;
      m_q     <= m_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      fl_q    <= fl_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
`ifdef FP_LOG_BASE_SEL_EN
      mode_q  <= mode_d;
      if (state_q == SCALE) p_q <= p_d;
`endif
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_y     = y_q;
  assign out_flags = fl_q;
endmodule

// File: tb/tb_fp_log_iter.sv
// tb_fp_log_iter: directed vectors for fp_log_iter (log2 results, specials,
// latency, backpressure, mid-operation reset).
module tb_fp_log_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = 32'h0;
  logic [1:0]  in_mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_y;
  logic [1:0]  out_flags;

  int n_vec = 0;
  int n_err = 0;

`ifdef FP_LOG_BASE_SEL_EN
  localparam int LAT = 28;
`else
  localparam int LAT = 27;
`endif

  fp_log_iter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  function automatic logic ulp1(input logic [31:0] a, input logic [31:0] b);
    longint d;
    d = longint'(a) - longint'(b);
    return (d >= -1) && (d <= 1);
  endfunction

  // Called #1 after an edge with the unit idle; returns #1 after handshake.
  task automatic do_op(input logic [31:0] x, input logic [1:0] md,
                       output logic [31:0] y, output logic [1:0] fl,
                       output int lat);
    in_x = x;
    in_mode = md;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    y = out_y;
    fl = out_flags;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic op_chk(input string tag, input logic [31:0] x,
                        input logic [1:0] md, input logic [31:0] ey,
                        input logic [1:0] ef, input int el);
    logic [31:0] y;
    logic [1:0]  fl;
    int          lat;
    do_op(x, md, y, fl, lat);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_fl"}, {30'd0, fl}, {30'd0, ef});
    chk({tag, "_lat"}, lat, el);
  endtask

  task automatic ulp_chk(input string tag, input logic [31:0] x,
                         input logic [1:0] md, input logic [31:0] ey);
    logic [31:0] y;
    logic [1:0]  fl;
    int          lat;
    do_op(x, md, y, fl, lat);
    chk({tag, "_ulp"}, {31'd0, ulp1(y, ey)}, 32'd1);
    chk({tag, "_lat"}, lat, LAT);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] y0;
    logic        stable;
    int          w;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_y", out_y, 32'h0);
    chk("rst_fl", {30'd0, out_flags}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    op_chk("l8",    32'h4100_0000, 2'b00, 32'h4040_0000, 2'b00, LAT);
    op_chk("lhalf", 32'h3F00_0000, 2'b00, 32'hBF80_0000, 2'b00, LAT);
    op_chk("dmin",  32'h0000_0001, 2'b00, 32'hC315_0000, 2'b00, LAT);
    op_chk("dmax",  32'h0040_0000, 2'b00, 32'hC2FE_0000, 2'b00, LAT);
    op_chk("nmin",  32'h0080_0000, 2'b00, 32'hC2FC_0000, 2'b00, LAT);
    op_chk("l2",    32'h4000_0000, 2'b00, 32'h3F80_0000, 2'b00, LAT);
    op_chk("l1024", 32'h4480_0000, 2'b00, 32'h4120_0000, 2'b00, LAT);
    op_chk("fmax",  32'h7F7F_FFFF, 2'b00, 32'h4300_0000, 2'b00, LAT);
    ulp_chk("l3",   32'h4040_0000, 2'b00, 32'h3FCA_E00D);

    op_chk("nzero", 32'h8000_0000, 2'b00, 32'hFF80_0000, 2'b01, 1);
    op_chk("pzero", 32'h0000_0000, 2'b00, 32'hFF80_0000, 2'b01, 1);
    op_chk("neg1",  32'hBF80_0000, 2'b00, 32'h7FC0_0000, 2'b10, 1);
    op_chk("ninf",  32'hFF80_0000, 2'b00, 32'h7FC0_0000, 2'b10, 1);
    op_chk("pinf",  32'h7F80_0000, 2'b00, 32'h7F80_0000, 2'b00, 1);
    op_chk("snan",  32'h7FA0_0000, 2'b00, 32'h7FC0_0000, 2'b10, 1);
    op_chk("qnan",  32'h7FC0_0000, 2'b00, 32'h7FC0_0000, 2'b00, 1);
    op_chk("one",   32'h3F80_0000, 2'b00, 32'h0000_0000, 2'b00, 1);

`ifdef FP_LOG_BASE_SEL_EN
    ulp_chk("ln8",  32'h4100_0000, 2'b01, 32'h4005_1592);
    ulp_chk("lg8",  32'h4100_0000, 2'b10, 32'h3F67_30DD);
    op_chk("m11",   32'h4100_0000, 2'b11, 32'h4040_0000, 2'b00, LAT);
`else
    op_chk("m01",   32'h4100_0000, 2'b01, 32'h4040_0000, 2'b00, LAT);
    op_chk("m10",   32'h4100_0000, 2'b10, 32'h4040_0000, 2'b00, LAT);
`endif

    in_x = 32'h4180_0000;
    in_mode = 2'b00;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_busy", {31'd0, in_ready}, 32'd0);
    w = 0;
    while (!out_valid && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    y0 = out_y;
    chk("bp_y", y0, 32'h4080_0000);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_y !== y0 || out_flags !== 2'b00 || out_valid !== 1'b1 ||
          in_ready !== 1'b0)
        stable = 1'b0;
    end
    chk("bp_hold", {31'd0, stable}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_rdy", {31'd0, in_ready}, 32'd1);
    chk("bp_vld", {31'd0, out_valid}, 32'd0);

    in_x = 32'h4100_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_vld", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ar_vld", {31'd0, out_valid}, 32'd0);
    chk("ar_rdy", {31'd0, in_ready}, 32'd1);
    chk("ar_y", out_y, 32'h0);
    op_chk("ar_l4", 32'h4080_0000, 2'b00, 32'h4000_0000, 2'b00, LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
